digit_convert_ctrl: RTL and testbench

Sequential controller that turns a binary value into six decimal digits for the display path. It replaces the large combinational divide/modulo chain with a shift-and-add-3 (double-dabble) engine that processes one bit per clock. It accepts one value at a time through a valid/ready handshake and presents registered digits plus an overflow flag with a one-cycle completion pulse. It sits between the measurement result registers and the seven-segment display drivers.

---
 rtl/digit_convert_ctrl_if.sv | 39 +++
 rtl/digit_convert_ctrl.sv | 106 ++++++++++
 tb/tb_digit_convert_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_convert_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_convert_ctrl_if
// Description : Request/result bundle between the measurement result
//               registers (master) and the digit conversion controller
//               (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_convert_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] numero;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy;
    logic [4:0]            digit0;
    logic [4:0]            digit1;
    logic [4:0]            digit2;
    logic [4:0]            digit3;
    logic [4:0]            digit4;
    logic [4:0]            digit5;
    logic                  overflow;
    logic                  out_valid;

    modport master (
        output numero, in_valid,
        input  in_ready, busy,
        input  digit0, digit1, digit2, digit3, digit4, digit5,
        input  overflow, out_valid
    );

    modport slave (
        input  numero, in_valid,
        output in_ready, busy,
        output digit0, digit1, digit2, digit3, digit4, digit5,
        output overflow, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/digit_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_convert_ctrl
// Description : Sequential binary-to-decimal converter. A double-dabble
//               (shift-and-add-3) engine processes one input bit per clock
//               into a 10-digit BCD register; the low six digits and an
//               overflow flag are registered out with a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_convert_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          reset,
    digit_convert_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter value seen on the final shift cycle.
    localparam logic [5:0] c_last_shift = 6'(DATA_WIDTH - 1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_bin_sr;
    logic [39:0]           r_bcd;
    logic [5:0]            r_cnt;
    logic [39:0]           w_bcd_adj;

    // Per-nibble add-3 correction; nibbles are independent (no carry chain).
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_add3
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? r_bcd[4*gi +: 4] + 4'd3
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    // Control FSM, shift datapath and registered result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bin_sr      <= '0;
            r_bcd         <= '0;
            r_cnt         <= '0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            bus.digit0    <= '0;
            bus.digit1    <= '0;
            bus.digit2    <= '0;
            bus.digit3    <= '0;
            bus.digit4    <= '0;
            bus.digit5    <= '0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        r_bin_sr     <= bus.numero;
                        r_bcd        <= '0;
                        r_cnt        <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Correct then shift the MSB of the binary word into BCD.
                    r_bcd    <= {w_bcd_adj[38:0], r_bin_sr[DATA_WIDTH-1]};
                    r_bin_sr <= {r_bin_sr[DATA_WIDTH-2:0], 1'b0};
                    r_cnt    <= r_cnt + 6'd1;
                    if (r_cnt == c_last_shift) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Low six digits are always published, even on overflow.
                    bus.digit0    <= {1'b0, r_bcd[3:0]};
                    bus.digit1    <= {1'b0, r_bcd[7:4]};
                    bus.digit2    <= {1'b0, r_bcd[11:8]};
                    bus.digit3    <= {1'b0, r_bcd[15:12]};
                    bus.digit4    <= {1'b0, r_bcd[19:16]};
                    bus.digit5    <= {1'b0, r_bcd[23:20]};
                    bus.overflow  <= |r_bcd[39:24];
                    bus.out_valid <= 1'b1;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    bus.in_ready <= 1'b1;
                    bus.busy     <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_convert_ctrl
// Description : Directed self-checking bench for digit_convert_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_convert_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   cycle;

    digit_convert_ctrl_if #(.DATA_WIDTH(32)) bus ();

    digit_convert_ctrl #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter used for pulse spacing.
    always @(posedge clk) cycle <= cycle + 1;

    // Pack the six 5-bit digit outputs, digit5 most significant.
    function automatic logic [29:0] digits_now();
        return {bus.digit5, bus.digit4, bus.digit3,
                bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // Expand a 6-nibble hex-coded decimal constant to 6 five-bit digits.
    function automatic logic [29:0] expand(input logic [23:0] h);
        logic [29:0] r;
        for (int n = 0; n < 6; n++) r[5*n +: 5] = {1'b0, h[4*n +: 4]};
        return r;
    endfunction

    // Golden arithmetic model: digit N = (v / 10^N) % 10.
    function automatic logic [29:0] golden(input logic [31:0] v);
        logic [29:0] r;
        longint      p;
        p = 1;
        for (int n = 0; n < 6; n++) begin
            r[5*n +: 5] = 5'((longint'(v) / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Wait for out_valid, counting edges on top of those already elapsed.
    task automatic wait_result(input int already, output int lat,
                               output logic [29:0] dig, output logic ov);
        lat = -1;
        dig = '0;
        ov  = 1'b0;
        for (int i = already + 1; i <= already + 100; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = i;
                dig = digits_now();
                ov  = bus.overflow;
                break;
            end
        end
    endtask

    // Present a value, complete the handshake, release in_valid.
    task automatic start_conv(input logic [31:0] v);
        for (int g = 0; g < 100 && !bus.in_ready; g++) begin
            @(posedge clk); #1;
        end
        bus.numero   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_conv(input logic [31:0] v, output int lat,
                           output logic [29:0] dig, output logic ov);
        start_conv(v);
        wait_result(0, lat, dig, ov);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.numero   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0
            || bus.overflow !== 1'b0 || digits_now() !== 30'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b busy=%b ov=%b ovf=%b dig=%h required 1 0 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.overflow, digits_now());
        end
    endtask

    task automatic test_basic();
        int lat; logic [29:0] dig; logic ov;
        start_conv(32'd123456);
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_during_shift: busy=%b rdy=%b required 1 0", bus.busy, bus.in_ready);
        end
        wait_result(1, lat, dig, ov);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL latency_123456: got %0d required 33", lat);
        end
        checks++;
        if (dig !== expand(24'h123456) || ov !== 1'b0) begin
            errors++;
            $display("FAIL value_123456: dig=%h ov=%b required %h 0", dig, ov, expand(24'h123456));
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_with_valid: rdy=%b busy=%b required 1 0", bus.in_ready, bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || digits_now() !== expand(24'h123456)) begin
            errors++;
            $display("FAIL pulse_and_hold: ov=%b dig=%h required 0 %h",
                     bus.out_valid, digits_now(), expand(24'h123456));
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [29:0] d1, d2;
        logic o1, o2;
        t1 = -1; t2 = -1; d1 = '0; d2 = '0; o1 = 1'b0; o2 = 1'b0;
        bus.numero   = 32'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.numero = 32'd999999;
        for (int i = 0; i < 120 && t2 < 0; i++) begin
            @(posedge clk); #1;
            if (t1 >= 0 && bus.in_valid && !bus.in_ready) bus.in_valid = 1'b0;
            if (bus.out_valid) begin
                if (t1 < 0) begin
                    t1 = cycle; d1 = digits_now(); o1 = bus.overflow;
                end else begin
                    t2 = cycle; d2 = digits_now(); o2 = bus.overflow;
                end
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (d1 !== 30'd0 || o1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_zero: dig=%h ov=%b required 0 0", d1, o1);
        end
        checks++;
        if (d2 !== expand(24'h999999) || o2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_999999: dig=%h ov=%b required %h 0", d2, o2, expand(24'h999999));
        end
        checks++;
        if (t1 < 0 || t2 - t1 !== 34) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 34", t2 - t1);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [29:0] dig; logic ov;
        do_conv(32'd1000000, lat, dig, ov);
        checks++;
        if (lat !== 33 || dig !== 30'd0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_1000000: lat=%0d dig=%h ov=%b required 33 0 1", lat, dig, ov);
        end
        do_conv(32'd4294967295, lat, dig, ov);
        checks++;
        if (lat !== 33 || dig !== expand(24'h967295) || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_max: lat=%0d dig=%h ov=%b required 33 %h 1",
                     lat, dig, ov, expand(24'h967295));
        end
        do_conv(32'd1000001, lat, dig, ov);
        checks++;
        if (dig !== expand(24'h000001) || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_1000001: dig=%h ov=%b required %h 1", dig, ov, expand(24'h000001));
        end
    endtask

    task automatic test_ignore_during_shift();
        int lat; logic [29:0] dig; logic ov;
        int bad;
        bad = 0;
        start_conv(32'd777777);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.in_ready !== 1'b0) bad++;
            bus.in_valid = i[0];
            bus.numero   = $urandom;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ready_low_in_shift: high on %0d cycles required 0", bad);
        end
        wait_result(20, lat, dig, ov);
        checks++;
        if (lat !== 33 || dig !== expand(24'h777777) || ov !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: lat=%0d dig=%h ov=%b required 33 %h 0",
                     lat, dig, ov, expand(24'h777777));
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL no_extra_accept: rdy=%b busy=%b required 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [29:0] dig; logic ov;
        int pulses;
        pulses = 0;
        start_conv(32'd654321);
        repeat (9) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0
            || bus.overflow !== 1'b0 || digits_now() !== 30'd0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b busy=%b ov=%b ovf=%b dig=%h required 1 0 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.overflow, digits_now());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_no_pulse: got %0d pulses required 0", pulses);
        end
        do_conv(32'd42, lat, dig, ov);
        checks++;
        if (lat !== 33 || dig !== expand(24'h000042) || ov !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_42: lat=%0d dig=%h ov=%b required 33 %h 0",
                     lat, dig, ov, expand(24'h000042));
        end
    endtask

    task automatic test_random();
        int lat; logic [29:0] dig; logic ov;
        logic [31:0] v;
        for (int k = 0; k < 250; k++) begin
            v = (k % 2 == 0) ? $urandom : 32'($urandom_range(0, 2000000));
            do_conv(v, lat, dig, ov);
            checks++;
            if (lat !== 33 || dig !== golden(v) || ov !== (v > 32'd999999)) begin
                errors++;
                $display("FAIL random_%0d: v=%0d lat=%0d dig=%h ov=%b required 33 %h %b",
                         k, v, lat, dig, ov, golden(v), (v > 32'd999999));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cycle  = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_ignore_during_shift();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
